// File: rtl/udp_pingpong_ctrl_pkg.sv
// Shared encodings for the UDP receive ping-pong RAM controller and the
// data checker that reads the frames back.
package udp_pp_pkg;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2,
      READ = 2'd3
   } bank_state_t;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_ACTIVE = 2'd1,
      R_REL    = 2'd2
   } rd_state_t;

   localparam logic [31:0] FRAME_HDR = 32'h3a87c5d6;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/udp_pingpong_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter: combinational pick plus registered
// one-hot grant; the last-granted requester loses the next tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       nRST,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] pick,
   output logic [1:0] gnt
);

   logic       prio_reg, prio_next;
   logic [1:0] gnt_reg;

   // prio_reg names the requester that wins a tie
   always_comb begin
      pick      = 2'b00;
      prio_next = prio_reg;
      if (en) begin
         if (req == 2'b11)
            pick = prio_reg ? 2'b10 : 2'b01;
         else
            pick = req;
         if (pick[0])
            prio_next = 1'b1;
         else if (pick[1])
            prio_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         prio_reg <= 1'b0;
         gnt_reg  <= 2'b00;
      end else begin
         prio_reg <= prio_next;
         gnt_reg  <= pick;
      end
   end

   assign gnt = gnt_reg;

endmodule

// File: rtl/udp_pingpong_ctrl.sv
// Owner of the two-bank UDP receive RAM: hands banks to the receiver,
// dispatches full banks to two readers in order and arbitrates the read port.
module udp_pingpong_ctrl
   import udp_pp_pkg::*;
#(
   parameter logic [15:0] TMO_CYC = 16'd4095,
   parameter int          AW      = 9
) (
   input  logic          clk,
   input  logic          nRST,
   input  logic          wr_frame_start,
   input  logic          wr_frame_end,
   output logic          wr_bank,
   output logic          wr_allow,
   output logic          pingpong,
   output logic          rd_bank,
   input  logic [1:0]    cfg_rd_en,
   input  logic [1:0]    rd_req,
   input  logic [AW-1:0] rd_addr0,
   input  logic [AW-1:0] rd_addr1,
   output logic [1:0]    rd_gnt,
   output logic [1:0]    rd_vld,
   input  logic [1:0]    rd_done,
   output logic [AW:0]   ram_addr,
   output logic [15:0]   drop_cnt,
   output logic [15:0]   tmo_cnt,
   output logic          busy
);

   bank_state_t bank_reg [2];
   bank_state_t bank_next [2];
   rd_state_t   rd_state_reg, rd_state_next;
   logic        wr_bank_reg, wr_bank_next;
   logic        wr_allow_reg, wr_allow_next;
   logic        pingpong_reg, pingpong_next;
   logic        rd_bank_reg, rd_bank_next;
   logic [1:0]  done_reg, done_next;
   logic [15:0] timer_reg, timer_next;
   logic [15:0] drop_cnt_reg, drop_cnt_next;
   logic [15:0] tmo_cnt_reg, tmo_cnt_next;
   logic [1:0]  rd_vld_reg, arb_pick;
   logic [AW:0] ram_addr_reg;

   // Write and read sides touch disjoint bank states (FREE/FILL vs FULL/READ),
   // so both may update bank_next in the same cycle without conflict.
   always_comb begin
      bank_next     = bank_reg;
      rd_state_next = rd_state_reg;
      wr_bank_next  = wr_bank_reg;
      pingpong_next = pingpong_reg;
      rd_bank_next  = rd_bank_reg;
      done_next     = done_reg;
      timer_next    = timer_reg;
      drop_cnt_next = drop_cnt_reg;
      tmo_cnt_next  = tmo_cnt_reg;

      if (wr_frame_start) begin
         if (bank_reg[wr_bank_reg] == FREE)
            bank_next[wr_bank_reg] = FILL;
         else
            drop_cnt_next = sat_inc(drop_cnt_reg);
      end else if (wr_frame_end && bank_reg[wr_bank_reg] == FILL) begin
         bank_next[wr_bank_reg] = FULL;
         wr_bank_next           = ~wr_bank_reg;
      end

      case (rd_state_reg)
         R_IDLE: begin
            if (bank_reg[rd_bank_reg] == FULL) begin
               bank_next[rd_bank_reg] = READ;
               pingpong_next          = ~pingpong_reg;
               done_next              = 2'b00;
               timer_next             = 16'd0;
               rd_state_next          = R_ACTIVE;
            end
         end
         R_ACTIVE: begin
            done_next  = done_reg | rd_done | ~cfg_rd_en;
            timer_next = timer_reg + 16'd1;
            if (done_reg == 2'b11) begin
               rd_state_next = R_REL;
            end else if (timer_reg == TMO_CYC) begin
               tmo_cnt_next  = sat_inc(tmo_cnt_reg);
               rd_state_next = R_REL;
            end
         end
         R_REL: begin
            bank_next[rd_bank_reg] = FREE;
            rd_bank_next           = ~rd_bank_reg;
            rd_state_next          = R_IDLE;
         end
         default: rd_state_next = R_IDLE;
      endcase

      wr_allow_next = (bank_next[wr_bank_next] == FREE);
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         bank_reg     <= '{FREE, FREE};
         rd_state_reg <= R_IDLE;
         wr_bank_reg  <= 1'b0;
         wr_allow_reg <= 1'b1;
         pingpong_reg <= 1'b0;
         rd_bank_reg  <= 1'b0;
         done_reg     <= 2'b00;
         timer_reg    <= 16'd0;
         drop_cnt_reg <= 16'd0;
         tmo_cnt_reg  <= 16'd0;
         rd_vld_reg   <= 2'b00;
         ram_addr_reg <= '0;
      end else begin
         bank_reg     <= bank_next;
         rd_state_reg <= rd_state_next;
         wr_bank_reg  <= wr_bank_next;
         wr_allow_reg <= wr_allow_next;
         pingpong_reg <= pingpong_next;
         rd_bank_reg  <= rd_bank_next;
         done_reg     <= done_next;
         timer_reg    <= timer_next;
         drop_cnt_reg <= drop_cnt_next;
         tmo_cnt_reg  <= tmo_cnt_next;
         // RAM answers one cycle after the address is presented
         rd_vld_reg   <= rd_gnt;
         if (arb_pick[0])
            ram_addr_reg <= {rd_bank_reg, rd_addr0};
         else if (arb_pick[1])
            ram_addr_reg <= {rd_bank_reg, rd_addr1};
      end
   end

   rr_arb2 u_arb (
      .clk  (clk),
      .nRST (nRST),
      .en   (rd_state_reg == R_ACTIVE),
      .req  (rd_req),
      .pick (arb_pick),
      .gnt  (rd_gnt)
   );

   assign wr_bank  = wr_bank_reg;
   assign wr_allow = wr_allow_reg;
   assign pingpong = pingpong_reg;
   assign rd_bank  = rd_bank_reg;
   assign rd_vld   = rd_vld_reg;
   assign ram_addr = ram_addr_reg;
   assign drop_cnt = drop_cnt_reg;
   assign tmo_cnt  = tmo_cnt_reg;
   assign busy     = (rd_state_reg != R_IDLE);

endmodule

// File: tb/tb_udp_pingpong_ctrl.sv
// Randomized bench for udp_pingpong_ctrl: a frame-level model predicts accepts,
// drops, dispatch order and timeouts; a scoreboard checks read data per reader.
module tb_udp_pingpong_ctrl;

   localparam int          AW  = 9;
   localparam logic [15:0] TMO = 16'd16;
   localparam logic [31:0] HDR = 32'h3a87c5d6;

   logic          clk = 1'b0;
   logic          nRST;
   logic          wr_frame_start, wr_frame_end;
   logic          wr_bank, wr_allow, pingpong, rd_bank, busy;
   logic [1:0]    cfg_rd_en, rd_req, rd_gnt, rd_vld, rd_done;
   logic [AW-1:0] rd_addr0, rd_addr1;
   logic [AW:0]   ram_addr;
   logic [15:0]   drop_cnt, tmo_cnt;

   logic          req_a  [2];
   logic [AW-1:0] addr_a [2];
   logic          done_a [2];
   assign rd_req   = {req_a[1], req_a[0]};
   assign rd_addr0 = addr_a[0];
   assign rd_addr1 = addr_a[1];
   assign rd_done  = {done_a[1], done_a[0]};

   udp_pingpong_ctrl #(.TMO_CYC(TMO), .AW(AW)) dut (
      .clk(clk), .nRST(nRST),
      .wr_frame_start(wr_frame_start), .wr_frame_end(wr_frame_end),
      .wr_bank(wr_bank), .wr_allow(wr_allow), .pingpong(pingpong), .rd_bank(rd_bank),
      .cfg_rd_en(cfg_rd_en), .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_done(rd_done), .ram_addr(ram_addr),
      .drop_cnt(drop_cnt), .tmo_cnt(tmo_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int disp_cyc = 0;
   logic pp_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // one-cycle-latency RAM behind the read port
   logic [31:0] mem [0:1023];
   logic [31:0] ram_data;
   always @(posedge clk) ram_data <= mem[ram_addr];

   logic [31:0] sb_q0[$];
   logic [31:0] sb_q1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] frame_word(input int f, input int w);
      logic [31:0] fv;
      fv = f;
      if (w == 11) return HDR;
      return {fv[15:0], 7'd0, 9'(w)};
   endfunction

   // monitor: every rd_vld pops the expected word for that reader
   always @(negedge clk) begin
      if (pingpong !== pp_prev) disp_cyc = cyc;
      pp_prev = pingpong;
      if (nRST) begin
         if (rd_vld == 2'b11 || rd_gnt == 2'b11) begin
            errors++;
            $display("FAIL onehot: vld=%b gnt=%b required at most one bit", rd_vld, rd_gnt);
         end
         if (rd_vld[0]) begin
            if (sb_q0.size() == 0) begin
               errors++;
               $display("FAIL vld0_unexpected: got vld with data %h, required no vld", ram_data);
            end else chk("rd_data0", ram_data, sb_q0.pop_front());
         end
         if (rd_vld[1]) begin
            if (sb_q1.size() == 0) begin
               errors++;
               $display("FAIL vld1_unexpected: got vld with data %h, required no vld", ram_data);
            end else chk("rd_data1", ram_data, sb_q1.pop_front());
         end
      end
   end

   // frame-level reference model
   int  m_drop, m_tmo, m_disp, fid;
   bit  m_free [2];
   bit  m_wr;
   int  pend_fid[$];
   bit  pend_bank[$];

   task automatic model_reset();
      m_drop = 0; m_tmo = 0; m_disp = 0;
      m_free[0] = 1; m_free[1] = 1; m_wr = 0;
      pend_fid.delete(); pend_bank.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rst(input string tag);
      chk({tag, "_wr_bank"},  32'(wr_bank),  0);
      chk({tag, "_wr_allow"}, 32'(wr_allow), 1);
      chk({tag, "_pingpong"}, 32'(pingpong), 0);
      chk({tag, "_rd_bank"},  32'(rd_bank),  0);
      chk({tag, "_rd_gnt"},   32'(rd_gnt),   0);
      chk({tag, "_rd_vld"},   32'(rd_vld),   0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
      chk({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
      chk({tag, "_tmo_cnt"},  32'(tmo_cnt),  0);
      chk({tag, "_busy"},     32'(busy),     0);
   endtask

   task automatic send_frame(input bit same_cycle_end);
      bit acc;
      wr_frame_start = 1'b1;
      wr_frame_end   = same_cycle_end;
      acc = m_free[m_wr];
      if (acc) begin
         for (int w = 0; w < 512; w++) mem[{m_wr, 9'(w)}] = frame_word(fid, w);
         m_free[m_wr] = 0;
      end else m_drop++;
      tick();
      wr_frame_start = 1'b0;
      wr_frame_end   = 1'b1;
      tick();
      wr_frame_end = 1'b0;
      if (acc) begin
         pend_fid.push_back(fid);
         pend_bank.push_back(m_wr);
         m_wr = !m_wr;
      end
      fid++;
   endtask

   task automatic do_reader(input int i, input int n, input bit b, input int f);
      int  w, t;
      bit  got;
      for (int k = 0; k < n; k++) begin
         w = (k == 0) ? 11 : int'($urandom_range(0, 511));
         req_a[i]  = 1'b1;
         addr_a[i] = 9'(w);
         got = 0;
         for (t = 0; t < 20 && !got; t++) begin
            tick();
            if (rd_gnt[i]) got = 1;
         end
         chk($sformatf("gnt%0d_wait_le2", i), 32'(got && t <= 2), 1);
         if (got) begin
            chk($sformatf("ram_addr%0d", i), 32'(ram_addr), 32'({b, 9'(w)}));
            if (i == 0) sb_q0.push_back(frame_word(f, w));
            else        sb_q1.push_back(frame_word(f, w));
         end
      end
      req_a[i] = 1'b0;
   endtask

   task automatic wait_dispatch(input bit b, output bit ok);
      ok = 0;
      for (int t = 0; t < 40; t++) begin
         if (busy && rd_bank == b) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_idle(input int lim, output bit ok);
      ok = 0;
      for (int t = 0; t < lim; t++) begin
         if (!busy) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic pulse_done();
      done_a[0] = cfg_rd_en[0];
      done_a[1] = cfg_rd_en[1];
      tick();
      done_a[0] = 1'b0;
      done_a[1] = 1'b0;
   endtask

   int  nf, n0, n1, f, elapsed;
   bit  b, ok, first, tmo_mode;

   initial begin
      nRST = 1'b0;
      wr_frame_start = 1'b0; wr_frame_end = 1'b0; cfg_rd_en = 2'b11;
      for (int i = 0; i < 2; i++) begin req_a[i] = 0; addr_a[i] = '0; done_a[i] = 0; end
      for (int a = 0; a < 1024; a++) mem[a] = 32'd0;
      model_reset();
      fid = 1;
      repeat (3) tick();
      check_rst("rst");
      nRST = 1'b1;
      tick();

      for (int it = 0; it < 12; it++) begin
         cfg_rd_en = 2'($urandom_range(1, 3));
         nf = (it == 0) ? 3 : int'($urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) begin
            wr_frame_end = 1'b1;   // stray end with no frame open: ignored
            tick();
            wr_frame_end = 1'b0;
         end
         for (int k = 0; k < nf; k++) send_frame($urandom_range(0, 3) == 0);
         tick();
         chk("wr_allow", 32'(wr_allow), 32'(m_free[m_wr]));
         chk("wr_bank",  32'(wr_bank),  32'(m_wr));
         chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));

         first = 1;
         while (pend_fid.size() > 0) begin
            b = pend_bank.pop_front();
            f = pend_fid.pop_front();
            wait_dispatch(b, ok);
            chk("dispatch_seen", 32'(ok), 1);
            m_disp++;
            chk("pingpong", 32'(pingpong), 32'(m_disp & 1));
            chk("rd_bank", 32'(rd_bank), 32'(b));
            tmo_mode = (it == 1 && first) || ($urandom_range(0, 4) == 0);
            if (!tmo_mode) begin
               n0 = cfg_rd_en[0] ? int'($urandom_range(1, first ? 2 : 4)) : 0;
               n1 = cfg_rd_en[1] ? int'($urandom_range(1, first ? 2 : 4)) : 0;
               fork
                  do_reader(0, n0, b, f);
                  do_reader(1, n1, b, f);
               join
               tick();
               tick();
               pulse_done();
               wait_idle(4, ok);
               chk("release_after_done", 32'(ok), 1);
            end else begin
               wait_idle(40, ok);
               elapsed = cyc - disp_cyc;
               chk("tmo_release_seen", 32'(ok), 1);
               chk("tmo_latency_ok", 32'(elapsed >= int'(TMO) && elapsed <= int'(TMO) + 3), 1);
               m_tmo++;
            end
            chk("tmo_cnt", 32'(tmo_cnt), 32'(m_tmo));
            m_free[b] = 1;
            first = 0;
         end
         tick();
         chk("idle_wr_allow", 32'(wr_allow), 1);
      end

      // asynchronous reset while a frame is being read
      cfg_rd_en = 2'b11;
      send_frame(1'b0);
      b = pend_bank.pop_front();
      f = pend_fid.pop_front();
      wait_dispatch(b, ok);
      chk("pre_rst_dispatch", 32'(ok), 1);
      #3;
      nRST = 1'b0;
      #1;
      check_rst("async_rst");
      model_reset();
      sb_q0.delete(); sb_q1.delete();
      tick();
      tick();
      nRST = 1'b1;
      tick();
      send_frame(1'b0);
      b = pend_bank.pop_front();
      f = pend_fid.pop_front();
      chk("post_rst_bank", 32'(b), 0);
      wait_dispatch(b, ok);
      chk("post_rst_dispatch", 32'(ok), 1);
      chk("post_rst_pingpong", 32'(pingpong), 1);
      chk("post_rst_wr_bank", 32'(wr_bank), 1);
      pulse_done();
      wait_idle(4, ok);
      chk("post_rst_release", 32'(ok), 1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish before 200us");
      $fatal(1, "watchdog");
   end

endmodule
